calc_input_ctrl: RTL and testbench
==================================

// Module: calc_input_ctrl
// PURPOSE
//  Upstream front end for calculator_fpga: turns a raw, bouncy go push-button plus op/operand switches into a clean go/op/in1/in2 command.
//  Captures operands once per press and holds go until the calculator reports done.
//  Latches the result and flags a calculator that never finishes.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles before the debounced button changes state (>=1)
//  TIMEOUT_CYCLES   64  max cycles go is held in WAIT without done before abort (>=1)
//  DATA_W           3   operand/result width
//  OP_W             2   opcode width
// PORTS
//  clk           in   1       single system clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  btn_go        in   1       raw asynchronous push-button, active high
//  sw_op         in   OP_W    opcode switches: 0=XOR 1=AND 2=SUB 3=ADD
//  sw_in1        in   DATA_W  operand A switches
//  sw_in2        in   DATA_W  operand B switches
//  calc_done     in   1       done from calculator_fpga
//  calc_out      in   DATA_W  out from calculator_fpga
//  go            out  1       command request to calculator_fpga
//  op            out  OP_W    captured opcode, stable while busy
//  in1           out  DATA_W  captured operand A, stable while busy
//  in2           out  DATA_W  captured operand B, stable while busy
//  result        out  DATA_W  calc_out latched at done
//  result_valid  out  1       result holds the answer to the latest command
//  timeout       out  1       sticky: latest command aborted by timeout
//  busy          out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, sync/debounce flops and counters 0. Reset mid-command drops go at that same edge; no result is latched.
//  - Sync: 2-flop synchronizer on btn_go. Sync/debounce flops run continuously in every state.
//  - Debounce: btn_db flips only after the synced input differs from btn_db for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
//  - Press = btn_db rising edge, a 1-cycle internal pulse.
//    Latency: btn_go first sampled high at edge E1 -> go/op/in1/in2 update at edge E(DEBOUNCE_CYCLES+3).
//  - FSM IDLE -> WAIT -> HOLD -> IDLE:
//    IDLE: on press, register sw_op/sw_in1/sw_in2 into op/in1/in2; go<=1; clear result_valid and timeout; clear tmo_cnt; ->WAIT.
//    WAIT: go stays 1. tmo_cnt increments each cycle.
//      calc_done=1: go<=0, result<=calc_out, result_valid<=1, ->HOLD.
//      Otherwise, when tmo_cnt reaches TIMEOUT_CYCLES-1: go<=0, timeout<=1, ->HOLD. done on that same cycle wins.
//    HOLD: go=0; wait for btn_db==0, then ->IDLE. Prevents auto-repeat while the button is held.
//  - Press pulses outside IDLE are discarded, not queued.
//  - op/in1/in2 change only at capture; switch activity during WAIT/HOLD has no effect.
//  - result/result_valid/timeout persist through HOLD and IDLE until the next capture.
//  - Counters saturate, never wrap. Count widths use $clog2(param+1).
// STRUCTURE
//  - calc_pkg: OP_XOR/OP_AND/OP_SUB/OP_ADD localparams, DATA_W/OP_W defaults, state encoding IDLE/WAIT/HOLD.
//  - Sub-module calc_debounce (param DEBOUNCE_CYCLES): synchronizer, debounce counter, btn_db output, rise-pulse output.
//  - Top level: FSM, operand/result registers, timeout counter.
// TESTING (bench params DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, calc_done modelled)
//  1. Clean press, sw_op=3 in1=5 in2=1, model done 3 cycles after go
//     -> go rises 7 edges after btn sampled, op=3 in1=5 in2=1; result=6, result_valid=1, go low the edge done is seen.
//  2. btn toggles every 2 cycles for 12 cycles, then held high
//     -> exactly one go assertion; no go during bounce.
//  3. During WAIT, switches change to op=0 in1=7 in2=7
//     -> op/in1/in2 stay 3/5/1; result=6.
//  4. done never asserted
//     -> go high for exactly 8 cycles, then timeout=1, result_valid=0; next press clears timeout.
//  5. Button held 50 cycles after done
//     -> single go; busy stays 1 until btn_db falls, then 0.
//  6. rst pulsed mid-WAIT
//     -> next edge: go=0, busy=0, op/in1/in2/result=0; a fresh press works normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcodes, default widths and FSM state encoding for the calculator input front end.
package calc_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int OP_W_DEF   = 2;

    localparam logic [1:0] OP_XOR = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/calc_debounce.sv
// Two-flop synchronizer and counter debouncer for a raw push-button.
// Also produces a one-cycle pulse on each debounced rising edge.
module calc_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d   = db_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
            end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // NOTE: non-blocking assignments so each sync stage captures the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db   = db_q;
    assign btn_rise = rise_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Front end for calculator_fpga: debounced go button, operand capture, go handshake,
// result latch and timeout detection for a calculator that never reports done.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int OP_W            = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_go,
    input  logic [OP_W-1:0]   sw_op,
    input  logic [DATA_W-1:0] sw_in1,
    input  logic [DATA_W-1:0] sw_in2,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_out,
    output logic              go,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic btn_db, press;

    calc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_go),
        .btn_db  (btn_db),
        .btn_rise(press)
    );

    state_e            state_q, state_d;
    logic              go_q, go_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        state_d        = state_q;
        go_d           = go_q;
        op_d           = op_q;
        in1_d          = in1_q;
        in2_d          = in2_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timeout_d      = timeout_q;
        tmo_cnt_d      = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (press) begin
                    op_d           = sw_op;
                    in1_d          = sw_in1;
                    in2_d          = sw_in2;
                    go_d           = 1'b1;
                    result_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                    tmo_cnt_d      = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                // A done arriving on the final timeout cycle still counts as success.
                if (calc_done) begin
                    go_d           = 1'b0;
                    result_d       = calc_out;
                    result_valid_d = 1'b1;
                    state_d        = HOLD;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    go_d      = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // Wait for release so a held button cannot auto-repeat.
                if (!btn_db) begin
                    state_d = IDLE;
                end
            end
            default: begin
                go_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            go_q           <= 1'b0;
            op_q           <= '0;
            in1_q          <= '0;
            in2_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            go_q           <= go_d;
            op_q           <= op_d;
            in1_q          <= in1_d;
            in2_q          <= in2_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign go           = go_q;
    assign op           = op_q;
    assign in1          = in1_q;
    assign in2          = in2_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Scoreboard bench for calc_input_ctrl: stimulus queues expected go-rise and go-fall
// responses; a negedge monitor pops and compares them as the DUT produces them.
module tb_calc_input_ctrl;

    localparam int DEB       = 4;
    localparam int TMO       = 8;
    localparam int DONE_DLY  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_go;
    logic [1:0] sw_op;
    logic [2:0] sw_in1, sw_in2;
    logic       calc_done = 1'b0;
    logic [2:0] calc_out  = 3'd0;
    logic       go;
    logic [1:0] op;
    logic [2:0] in1, in2, result;
    logic       result_valid, timeout, busy;

    calc_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .DATA_W         (3),
        .OP_W           (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_go      (btn_go),
        .sw_op       (sw_op),
        .sw_in1      (sw_in1),
        .sw_in2      (sw_in2),
        .calc_done   (calc_done),
        .calc_out    (calc_out),
        .go          (go),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .result      (result),
        .result_valid(result_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] in1;
        logic [2:0] in2;
        int         rise;
    } cmd_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] in1;
        logic [2:0] in2;
        logic [2:0] res;
        logic       rv;
        logic       to;
        int         dur;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];

    // Calculator model: raises done DONE_DLY cycles after go when enabled.
    bit done_en = 1'b1;
    int hi_cnt  = 0;
    always @(negedge clk) begin
        if (go && done_en && !rst) begin
            hi_cnt++;
            if (hi_cnt == DONE_DLY) begin
                calc_done = 1'b1;
                case (op)
                    2'd0:    calc_out = in1 ^ in2;
                    2'd1:    calc_out = in1 & in2;
                    2'd2:    calc_out = in1 - in2;
                    default: calc_out = in1 + in2;
                endcase
            end else begin
                calc_done = 1'b0;
            end
        end else begin
            hi_cnt    = 0;
            calc_done = 1'b0;
        end
    end

    // Monitor: go rising pops a command expectation, go falling pops a completion.
    logic go_prev  = 1'b0;
    int   rise_cyc = 0;
    always @(negedge clk) begin
        if (go && !go_prev) begin
            rise_cyc = cyc;
            check("go_rise_expected", cmd_q.size() > 0, 1);
            if (cmd_q.size() > 0) begin
                cmd_t c;
                c = cmd_q.pop_front();
                check("rise_cycle", cyc, c.rise);
                check("rise_op", op, c.op);
                check("rise_in1", in1, c.in1);
                check("rise_in2", in2, c.in2);
                check("rise_flags_clear", {result_valid, timeout}, 0);
                check("rise_busy", busy, 1);
            end
        end
        if (!go && go_prev) begin
            check("go_fall_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                done_t d;
                d = done_q.pop_front();
                check("go_high_cycles", cyc - rise_cyc, d.dur);
                check("fall_op", op, d.op);
                check("fall_in1", in1, d.in1);
                check("fall_in2", in2, d.in2);
                check("fall_result", result, d.res);
                check("fall_result_valid", result_valid, d.rv);
                check("fall_timeout", timeout, d.to);
            end
        end
        go_prev = go;
    end

    // Call right after a negedge: sets switches, raises the button, queues expectations.
    task automatic issue(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] fo, input logic [2:0] fa, input logic [2:0] fb,
                         input logic [2:0] res, input logic rv, input logic to, input int dur);
        cmd_t  c;
        done_t d;
        sw_op  = o;
        sw_in1 = a;
        sw_in2 = b;
        c = '{op: o, in1: a, in2: b, rise: cyc + DEB + 3};
        d = '{op: fo, in1: fa, in2: fb, res: res, rv: rv, to: to, dur: dur};
        cmd_q.push_back(c);
        done_q.push_back(d);
        btn_go = 1'b1;
    endtask

    task automatic wait_go(input logic lvl, input int budget);
        int k = 0;
        while (go !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_go_level", go, lvl);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    task automatic settle();
        repeat (DEB + 4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst    = 1'b1;
        btn_go = 1'b0;
        sw_op  = 2'd0;
        sw_in1 = 3'd0;
        sw_in2 = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {go, busy, op, in1, in2, result, result_valid, timeout}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean press ADD 5+1, switches disturbed during WAIT.
        issue(2'd3, 3'd5, 3'd1, 2'd3, 3'd5, 3'd1, 3'd6, 1'b1, 1'b0, DONE_DLY);
        wait_go(1'b1, 30);
        sw_op  = 2'd0;
        sw_in1 = 3'd7;
        sw_in2 = 3'd7;
        wait_go(1'b0, 20);
        btn_go = 1'b0;
        wait_idle(20);
        check("result_after_idle", result, 6);
        settle();

        // Bouncing button: toggles every 2 cycles, then held; AND 6&3=2.
        sw_op  = 2'd1;
        sw_in1 = 3'd6;
        sw_in2 = 3'd3;
        for (int i = 0; i < 12; i++) begin
            btn_go = ((i % 4) < 2);
            @(negedge clk);
        end
        issue(2'd1, 3'd6, 3'd3, 2'd1, 3'd6, 3'd3, 3'd2, 1'b1, 1'b0, DONE_DLY);
        wait_go(1'b1, 30);
        wait_go(1'b0, 20);
        btn_go = 1'b0;
        wait_idle(20);
        settle();

        // Calculator never answers: timeout after TMO cycles, old result kept.
        done_en = 1'b0;
        issue(2'd2, 3'd2, 3'd5, 2'd2, 3'd2, 3'd5, 3'd2, 1'b0, 1'b1, TMO);
        wait_go(1'b1, 30);
        btn_go = 1'b0;
        wait_go(1'b0, 20);
        wait_idle(20);
        check("timeout_sticky", timeout, 1);
        check("timeout_result_valid", result_valid, 0);
        settle();

        // Next press clears timeout: XOR 5^3=6.
        done_en = 1'b1;
        issue(2'd0, 3'd5, 3'd3, 2'd0, 3'd5, 3'd3, 3'd6, 1'b1, 1'b0, DONE_DLY);
        wait_go(1'b1, 30);
        btn_go = 1'b0;
        wait_go(1'b0, 20);
        wait_idle(20);
        check("timeout_cleared", timeout, 0);
        settle();

        // Button held 50 cycles after done: busy until debounced release. ADD 7+2=1.
        issue(2'd3, 3'd7, 3'd2, 2'd3, 3'd7, 3'd2, 3'd1, 1'b1, 1'b0, DONE_DLY);
        wait_go(1'b1, 30);
        wait_go(1'b0, 20);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("busy_while_held", bad, 0);
        btn_go = 1'b0;
        repeat (DEB + 2) @(negedge clk);
        check("busy_before_release_seen", busy, 1);
        @(negedge clk);
        check("busy_after_release", busy, 0);
        settle();

        // Reset mid-WAIT drops go and clears everything.
        done_en = 1'b0;
        issue(2'd3, 3'd1, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3);
        wait_go(1'b1, 30);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        btn_go = 1'b0;
        @(negedge clk);
        check("mid_wait_reset", {go, busy, op, in1, in2, result, result_valid, timeout}, 0);
        rst = 1'b0;
        settle();

        // Fresh press after reset: SUB 6-1=5.
        done_en = 1'b1;
        issue(2'd2, 3'd6, 3'd1, 2'd2, 3'd6, 3'd1, 3'd5, 1'b1, 1'b0, DONE_DLY);
        wait_go(1'b1, 30);
        btn_go = 1'b0;
        wait_go(1'b0, 20);
        wait_idle(20);
        settle();

        check("scoreboard_drained", cmd_q.size() + done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
